// File: rtl/chmon_pkg.sv
// rtl/chmon_pkg.sv - shared state encoding and width helpers for the channel activity monitor.
package chmon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } chmon_state_e;

  function automatic int win_w(input int window);
    return (window > 2) ? $clog2(window) : 1;
  endfunction

  // A single channel still needs a 1-bit select so the port never collapses to zero width.
  function automatic int sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic logic [63:0] cnt_max(input int cnt_w);
    return (cnt_w >= 64) ? {64{1'b1}} : ((64'd1 << cnt_w) - 64'd1);
  endfunction

endpackage

// File: rtl/channel_activity_monitor_if.sv
// rtl/channel_activity_monitor_if.sv - control, channel and readout signals of the activity monitor.
interface channel_activity_monitor_if #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16
);
  localparam int SEL_W = chmon_pkg::sel_w(NUM_CH);

  logic              en_i;
  logic              clr_i;
  logic [NUM_CH-1:0] ch_i;
  logic [SEL_W-1:0]  rd_sel_i;
  logic [CNT_W-1:0]  rd_cnt_o;
  logic [NUM_CH-1:0] idle_o;
  logic [NUM_CH-1:0] stuck_val_o;
  logic              win_done_o;
  logic              busy_o;

  modport master (
    output en_i, clr_i, ch_i, rd_sel_i,
    input  rd_cnt_o, idle_o, stuck_val_o, win_done_o, busy_o
  );

  modport slave (
    input  en_i, clr_i, ch_i, rd_sel_i,
    output rd_cnt_o, idle_o, stuck_val_o, win_done_o, busy_o
  );

endinterface

// File: rtl/chmon_channel.sv
// rtl/chmon_channel.sv - per-channel previous sample, edge detect and saturating toggle counter.
module chmon_channel
  import chmon_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ch,
  input  logic             i_prime,
  input  logic             i_run,
  input  logic             i_close,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_cnt_final
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_toggle;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_toggle   = i_run && (i_ch != r_prev);
  assign w_cnt_next = (w_toggle && (r_cnt != CNT_MAX)) ? r_cnt + 1'b1 : r_cnt;
  // Includes this cycle's toggle so the closing cycle lands in the reported window.
  assign o_cnt_final = w_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else begin
      if (i_prime || i_run) begin
        r_prev <= i_ch;
      end
      if (i_run) begin
        r_cnt <= i_close ? '0 : w_cnt_next;
      end
    end
  end

endmodule

// File: rtl/channel_activity_monitor.sv
// rtl/channel_activity_monitor.sv - windowed toggle monitor: FSM, window counter, snapshot and readout.
module channel_activity_monitor
  import chmon_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int WINDOW = 1024,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  channel_activity_monitor_if.slave   bus
);

  localparam int               WIN_W    = win_w(WINDOW);
  localparam int               SEL_W    = sel_w(NUM_CH);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  chmon_state_e      r_state;
  logic [WIN_W-1:0]  r_win;
  logic              r_busy;
  logic              r_win_done;
  logic [NUM_CH-1:0] r_idle;
  logic [NUM_CH-1:0] r_stuck;
  logic [CNT_W-1:0]  r_bank [NUM_CH];
  logic [CNT_W-1:0]  r_rd_cnt;

  logic [CNT_W-1:0]  w_final [NUM_CH];
  logic [SEL_W-1:0]  w_sel;
  logic              w_prime;
  logic              w_run;
  logic              w_close;

  // Clear outranks everything, including a window that would close this cycle.
  assign w_prime = (r_state == PRIME) && !bus.clr_i;
  assign w_run   = (r_state == RUN) && !bus.clr_i;
  assign w_close = w_run && (r_win == WIN_LAST);
  assign w_sel   = bus.rd_sel_i;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      chmon_channel #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ch        (bus.ch_i[c]),
        .i_prime     (w_prime),
        .i_run       (w_run),
        .i_close     (w_close),
        .i_clear     (bus.clr_i),
        .o_cnt_final (w_final[c])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_win      <= '0;
      r_busy     <= 1'b0;
      r_win_done <= 1'b0;
    end else begin
      r_win_done <= 1'b0;
      if (bus.clr_i) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_win   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.en_i) begin
              r_state <= PRIME;
              r_busy  <= 1'b1;
            end
          end
          PRIME: begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
          RUN: begin
            // The cycle that sees en_i low still counts; the pause starts after it.
            r_win      <= w_close ? '0 : r_win + 1'b1;
            r_win_done <= w_close;
            if (!bus.en_i) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle  <= '0;
      r_stuck <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_bank[c] <= '0;
      end
    end else if (w_close) begin
      r_stuck <= bus.ch_i;
      for (int c = 0; c < NUM_CH; c++) begin
        r_idle[c] <= (w_final[c] == '0);
        r_bank[c] <= w_final[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt <= '0;
    end else if (32'(w_sel) < NUM_CH) begin
      r_rd_cnt <= r_bank[w_sel];
    end else begin
      r_rd_cnt <= '0;
    end
  end

  assign bus.rd_cnt_o    = r_rd_cnt;
  assign bus.idle_o      = r_idle;
  assign bus.stuck_val_o = r_stuck;
  assign bus.win_done_o  = r_win_done;
  assign bus.busy_o      = r_busy;

endmodule
